// File: rtl/melody_sequencer.sv
// Song-table sequencer: fetches note entries, drives the tone generator with a load
// strobe, gates the tone for the note's duration and inserts a silent gap between notes.
module melody_sequencer #(
  parameter int BEAT_CLKS = 12500000,
  parameter int GAP_CLKS  = 500000,
  parameter int SONG_LEN  = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [3:0]        tone_note,
  output logic [2:0]        tone_octave,
  output logic [3:0]        tone_volume,
  output logic              tone_load,
  output logic              tone_enable,
  output logic              busy,
  output logic [ADDR_W-1:0] step_idx,
  output logic              done,
  output logic [1:0]        fsm_state
);

  localparam int BEAT_W = (BEAT_CLKS > 1) ? $clog2(BEAT_CLKS) : 1;
  localparam int GAP_W  = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CLKS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(SONG_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PLAY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [15:0]         song_tbl [SONG_LEN];
  logic [ADDR_W-1:0]   idx_next;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [4:0]          beats_left;
  logic                load_entry;
  logic                done_next;
  logic                end_hit;
  logic                advance;

  logic [15:0] cur_entry;
  logic [3:0]  cur_note;
  logic [4:0]  cur_dur;
  logic        is_end;
  logic        beat_wrap;

  assign cur_entry = song_tbl[step_idx];
  assign cur_note  = cur_entry[15:12];
  assign cur_dur   = cur_entry[4:0];
  assign is_end    = (cur_dur == 5'd0);
  assign beat_wrap = (beat_cnt == BEAT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SONG_LEN; i++) song_tbl[i] <= '0;
    end else if (wr_en) begin
      song_tbl[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    idx_next   = step_idx;
    load_entry = 1'b0;
    done_next  = 1'b0;
    end_hit    = 1'b0;
    advance    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
          idx_next   = '0;
        end
      end
      S_FETCH: begin
        if (is_end) begin
          end_hit = 1'b1;
        end else begin
          state_next = S_PLAY;
          load_entry = 1'b1;
        end
      end
      S_PLAY: begin
        if (beat_wrap && beats_left == 5'd1) begin
          if (GAP_CLKS > 0) state_next = S_GAP;
          else              advance    = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) advance = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase

    // Running off the last index is handled exactly like an end marker.
    if (advance && step_idx != IDX_LAST) begin
      idx_next   = step_idx + 1'b1;
      state_next = S_FETCH;
    end else if (advance || end_hit) begin
      if (loop && step_idx != '0) begin
        idx_next   = '0;
        state_next = S_FETCH;
      end else begin
        state_next = S_IDLE;
        done_next  = 1'b1;
      end
    end

    // Stop overrides everything, including a start in the same cycle.
    if (stop) begin
      state_next = S_IDLE;
      idx_next   = step_idx;
      load_entry = 1'b0;
      done_next  = 1'b0;
    end
  end

  always_comb begin
    busy      = (state != S_IDLE);
    fsm_state = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_idx    <= '0;
      done        <= 1'b0;
      tone_load   <= 1'b0;
      tone_enable <= 1'b0;
      tone_note   <= '0;
      tone_octave <= '0;
      tone_volume <= '0;
      beats_left  <= '0;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      step_idx    <= idx_next;
      done        <= done_next;
      tone_load   <= load_entry;
      tone_enable <= (state_next == S_PLAY) &&
                     (load_entry ? (cur_note <= 4'd11) : tone_enable);
      if (load_entry) begin
        tone_note   <= cur_note;
        tone_octave <= cur_entry[11:9];
        tone_volume <= cur_entry[8:5];
        beats_left  <= cur_dur;
        beat_cnt    <= '0;
      end else if (state == S_PLAY) begin
        if (beat_wrap) begin
          beat_cnt   <= '0;
          beats_left <= beats_left - 5'd1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (state != S_GAP) gap_cnt <= '0;
      else                gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with BEAT_CLKS=4, GAP_CLKS=2, SONG_LEN=4;
// expected traces are hand-computed cycle by cycle from the start pulse.
module tb_melody_sequencer;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic [3:0]    tone_note;
  logic [2:0]    tone_octave;
  logic [3:0]    tone_volume;
  logic          tone_load;
  logic          tone_enable;
  logic          busy;
  logic [AW-1:0] step_idx;
  logic          done;
  logic [1:0]    fsm_state;

  int passed = 0;
  int total  = 0;

  melody_sequencer #(
    .BEAT_CLKS(4), .GAP_CLKS(2), .SONG_LEN(4), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop),
    .tone_note(tone_note), .tone_octave(tone_octave), .tone_volume(tone_volume),
    .tone_load(tone_load), .tone_enable(tone_enable), .busy(busy),
    .step_idx(step_idx), .done(done), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // driver tasks
  function automatic logic [15:0] ent(logic [3:0] n, logic [2:0] o, logic [3:0] v, logic [4:0] d);
    return {n, o, v, d};
  endfunction

  task automatic write_entry(input logic [AW-1:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] exp_v, got_v;
    do_reset();
    total++;
    if ({tone_note, tone_octave, tone_volume} !== 11'd0) $display("FAIL reset_tone got=%h exp=0", {tone_note, tone_octave, tone_volume});
    else passed++;
    got_v = {tone_load, tone_enable, busy, done, step_idx, 1'b0};
    total++;
    if (got_v !== 7'd0) $display("FAIL reset_ctrl got=%b exp=0", got_v);
    else passed++;
    // empty table: one FETCH cycle then done
    pulse_start();
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) tick();
      exp_v = {(k == 1), 1'b0, 1'b0, (k == 2), 2'd0, 1'b0};
      got_v = {busy, tone_load, tone_enable, done, step_idx, 1'b0};
      total++;
      if (got_v !== exp_v) $display("FAIL empty_song k=%0d got=%b exp=%b", k, got_v, exp_v);
      else passed++;
    end
  endtask

  task automatic test_two_notes();
    logic [5:0] exp_v, got_v;
    do_reset();
    write_entry(2'd0, ent(4'd9, 3'd4, 4'd10, 5'd2));
    write_entry(2'd1, ent(4'd0, 3'd5, 4'd5, 5'd1));
    write_entry(2'd2, 16'd0);
    pulse_start();
    for (int k = 1; k <= 21; k++) begin
      if (k > 1) tick();
      exp_v[5]   = (k <= 19);
      exp_v[4]   = (k == 2 || k == 13);
      exp_v[3]   = (k >= 2 && k <= 9) || (k >= 13 && k <= 16);
      exp_v[2]   = (k == 20);
      exp_v[1:0] = (k >= 19) ? 2'd2 : (k >= 12) ? 2'd1 : 2'd0;
      got_v = {busy, tone_load, tone_enable, done, step_idx};
      total++;
      if (got_v !== exp_v) $display("FAIL two_notes k=%0d got=%b exp=%b", k, got_v, exp_v);
      else passed++;
      if (k == 2 || k == 13) begin
        total++;
        if ({tone_note, tone_octave, tone_volume} !== ((k == 2) ? {4'd9, 3'd4, 4'd10} : {4'd0, 3'd5, 4'd5}))
          $display("FAIL two_notes_params k=%0d got=%h/%h/%h", k, tone_note, tone_octave, tone_volume);
        else passed++;
      end
    end
  endtask

  task automatic test_rest();
    logic [5:0] exp_v, got_v;
    do_reset();
    write_entry(2'd0, ent(4'd15, 3'd0, 4'd3, 5'd1));
    pulse_start();
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) tick();
      exp_v = {(k <= 8), (k == 2), 1'b0, (k == 9), (k >= 8) ? 2'd1 : 2'd0};
      got_v = {busy, tone_load, tone_enable, done, step_idx};
      total++;
      if (got_v !== exp_v) $display("FAIL rest k=%0d got=%b exp=%b", k, got_v, exp_v);
      else passed++;
    end
  endtask

  task automatic test_loop();
    do_reset();
    write_entry(2'd0, ent(4'd1, 3'd4, 4'd8, 5'd1));
    write_entry(2'd1, ent(4'd2, 3'd4, 4'd8, 5'd1));
    loop = 1'b1;
    pulse_start();
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b1) $display("FAIL loop_busy k=%0d done=%b busy=%b exp 0/1", k, done, busy);
      else passed++;
      if (k == 15 || k == 16) begin
        total++;
        if (step_idx !== ((k == 15) ? 2'd2 : 2'd0)) $display("FAIL loop_idx k=%0d got=%0d", k, step_idx);
        else passed++;
      end
    end
    total++;
    if (tone_load !== 1'b1 || tone_note !== 4'd1) $display("FAIL loop_replay load=%b note=%0d exp 1/1", tone_load, tone_note);
    else passed++;
    stop = 1'b1; tick(); stop = 1'b0;
    // all four valid, no loop: done after index-3 gap
    loop = 1'b0;
    write_entry(2'd2, ent(4'd3, 3'd4, 4'd8, 5'd1));
    write_entry(2'd3, ent(4'd4, 3'd4, 4'd8, 5'd1));
    pulse_start();
    for (int k = 1; k <= 29; k++) begin
      if (k > 1) tick();
      if (k == 22 || k == 28 || k == 29) begin
        total++;
        if ({busy, done, step_idx} !== ((k == 29) ? {1'b0, 1'b1, 2'd3} : {1'b1, 1'b0, 2'd3}))
          $display("FAIL full_song k=%0d busy=%b done=%b idx=%0d", k, busy, done, step_idx);
        else passed++;
      end
    end
  endtask

  task automatic test_stop_and_reset();
    do_reset();
    write_entry(2'd0, ent(4'd9, 3'd4, 4'd10, 5'd2));
    pulse_start();
    tick(); tick(); tick();
    total++;
    if (tone_enable !== 1'b1) $display("FAIL stop_pre en=%b exp=1", tone_enable);
    else passed++;
    stop = 1'b1; tick(); stop = 1'b0;
    total++;
    if ({tone_enable, busy, done} !== 3'b000) $display("FAIL stop en/busy/done=%b exp=000", {tone_enable, busy, done});
    else passed++;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || fsm_state !== 2'd0) $display("FAIL start_stop busy=%b state=%0d exp 0/0", busy, fsm_state);
    else passed++;
    // writing the playing entry leaves the latched note alone
    pulse_start();
    tick(); tick();
    write_entry(2'd0, ent(4'd7, 3'd1, 4'd1, 5'd2));
    total++;
    if (tone_note !== 4'd9 || tone_enable !== 1'b1) $display("FAIL live_write note=%0d en=%b exp 9/1", tone_note, tone_enable);
    else passed++;
    do_reset();
    total++;
    if ({busy, tone_enable, tone_note} !== 6'd0) $display("FAIL mid_reset got=%b exp=0", {busy, tone_enable, tone_note});
    else passed++;
    pulse_start();
    tick();
    total++;
    if ({busy, done, tone_load} !== 3'b010) $display("FAIL reset_cleared got=%b exp=010", {busy, done, tone_load});
    else passed++;
  endtask

  task automatic test_loop_empty();
    do_reset();
    loop = 1'b1;
    pulse_start();
    total++;
    if (busy !== 1'b1 || fsm_state !== 2'd1) $display("FAIL loop_empty_fetch busy=%b state=%0d", busy, fsm_state);
    else passed++;
    tick();
    total++;
    if ({busy, done} !== 2'b01) $display("FAIL loop_empty_done got=%b exp=01", {busy, done});
    else passed++;
    tick();
    total++;
    if ({busy, done} !== 2'b00) $display("FAIL loop_empty_idle got=%b exp=00", {busy, done});
    else passed++;
    loop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_two_notes();
    test_rest();
    test_loop();
    test_stop_and_reset();
    test_loop_empty();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Plays a stored melody by sequencing the runtime-configurable tone generator datapath, one note after another. The block holds a small song table of note entries, each with note, octave, volume and duration, loaded through a write port. For each entry it presents the tone parameters with a load strobe, gates the tone for the note's duration, then inserts a silent gap between notes. It sits between the board control logic (start, stop, loop) and the tone generator / audio sink path.

Parameters:
BEAT_CLKS, 12500000, clocks per beat (250 ms at 50 MHz); must be at least 1
GAP_CLKS, 500000, silent clocks after each entry (10 ms); 0 means no gap state
SONG_LEN, 16, number of table entries; must be a power of two and at least 2
ADDR_W, 4, index width, equal to log2(SONG_LEN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  table write strobe
wr_addr  in  ADDR_W  table write index
wr_data  in  16  entry: [15:12] note, [11:9] octave, [8:5] volume, [4:0] duration in beats
start  in  1  begin playback from index 0 (single-cycle pulse)
stop  in  1  abort playback (single-cycle pulse)
loop  in  1  level; when high, restart at index 0 after end of song
tone_note  out  4  note to tone generator, 0..11 (C..B)
tone_octave  out  3  octave to tone generator
tone_volume  out  4  volume code to tone generator
tone_load  out  1  one-cycle strobe; tone_* parameters are new this cycle
tone_enable  out  1  high while an audible note sounds
busy  out  1  high in any state other than IDLE
step_idx  out  ADDR_W  index of the entry being fetched or played
done  out  1  one-cycle pulse on natural end of song

Behaviour:
- Reset is synchronous and active-high. It clears all table entries to 0 (all entries become end markers) and puts the FSM in IDLE. All outputs reset to 0. Reset in the middle of playback behaves the same way.
- Table: SONG_LEN x 16 registers.
  - When wr_en=1, wr_data is written at wr_addr on the next edge. Writes are accepted in any state.
  - An entry with duration 0 is an end marker.
  - Note codes 12..15 are rests.
- FSM states: IDLE, FETCH, PLAY, GAP.
- IDLE:
  - tone_enable=0, busy=0.
  - start=1 and stop=0 -> FETCH with step_idx=0.
- FETCH (1 cycle): reads table[step_idx] combinationally.
  - End marker, loop=1, step_idx!=0 -> step_idx=0, stay in FETCH.
  - End marker otherwise -> IDLE with done=1 for one cycle. This includes an end marker at index 0 with loop=1, so there is no lock-up.
  - Valid entry -> register tone_note/octave/volume, tone_load=1 for one cycle, and go to PLAY. tone_enable=1 if note<=11, otherwise 0 (rest). Load beats_left=duration and beat_cnt=0.
- PLAY:
  - Lasts exactly duration*BEAT_CLKS cycles.
  - beat_cnt counts 0..BEAT_CLKS-1. On wrap, beats_left is decremented. When the last beat wraps, go to GAP (or straight to ADVANCE if GAP_CLKS=0).
- GAP:
  - tone_enable=0 for exactly GAP_CLKS cycles, then ADVANCE.
- ADVANCE (a transition, not a state):
  - If step_idx=SONG_LEN-1, treat it as an end marker and apply the FETCH end-marker rules.
  - Otherwise step_idx+1 -> FETCH.
- Per-entry period is 1 + duration*BEAT_CLKS + GAP_CLKS cycles. tone_load is asserted on the first PLAY cycle, i.e. the edge after FETCH.
- stop=1 in any non-IDLE state -> IDLE on the next edge with tone_enable=0, busy=0, no done pulse. If start and stop are asserted in the same cycle, stop wins.
- start while busy is ignored.
- Writing the entry currently playing does not alter the latched tone_*; the new value takes effect on its next fetch.
- Counter widths: beat_cnt holds BEAT_CLKS-1, gap_cnt holds GAP_CLKS-1, beats_left is 5 bits. There is no overflow path.

Test Plan:
All scenarios use BEAT_CLKS=4, GAP_CLKS=2, SONG_LEN=4.
1. Reset pulse -> all outputs 0, busy=0. Then start with an empty table -> one FETCH cycle, done=1, back to IDLE, tone_load never asserted.
2. Write e0={note 9, oct 4, vol 10, dur 2}, e1={note 0, oct 5, vol 5, dur 1}, e2=0. Pulse start.
   - FETCH, then tone_load with 9/4/10 and tone_enable high for 8 cycles, low for 2.
   - Next entry: tone_load with 0/5/5, high for 4 cycles, low for 2.
   - FETCH of e2, then done=1 and busy=0. Total 19 cycles from start.
3. Entry note=15, dur=1 -> tone_load=1 but tone_enable stays 0 for 4+2 cycles; step_idx still advances.
4. Two entries plus end marker, loop=1 -> after e1's gap, step_idx returns to 0 and e0 replays; no done pulse. Same table with all 4 entries valid and loop=0 -> done after the index-3 gap.
5. Stop in the 3rd PLAY cycle -> next cycle tone_enable=0, busy=0, done=0. start+stop in the same cycle from IDLE -> stays IDLE. Reset mid-PLAY -> IDLE and a subsequent start yields immediate done (table cleared).
6. e0 end marker, loop=1, start -> done after one FETCH cycle, IDLE, no hang.
